// File: rtl/imm_rotate_encoder_pkg.sv
// Shared types and constants for the rotate-immediate encoder and the operand-2 decoder.
// Holds widths, FSM state encoding, shifter codes and the {rot, imm8} operand layout.
package imm_rotate_encoder_pkg;

  localparam int WORD_WIDTH            = 32;
  localparam int SHIFTER_OPERAND_WIDTH = 12;
  localparam int ROT_STEPS             = 16;
  localparam int ROT_WIDTH             = 4;
  localparam int IMM_WIDTH             = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    INV_SEARCH,
    PUBLISH
  } enc_state_e;

  // Shift-type codes as seen by the operand-2 decoder.
  typedef logic [1:0] shift_code_t;
  localparam shift_code_t SHIFT_LSL = 2'b00;
  localparam shift_code_t SHIFT_LSR = 2'b01;
  localparam shift_code_t SHIFT_ASR = 2'b10;
  localparam shift_code_t SHIFT_ROR = 2'b11;

  typedef struct packed {
    logic [ROT_WIDTH-1:0] rot;
    logic [IMM_WIDTH-1:0] imm8;
  } shifter_operand_t;

endpackage

// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle of the rotate-immediate encoder.
// master drives start/value_in; slave (the encoder) returns status and the encoded operand.
interface imm_rotate_encoder_if;
  import imm_rotate_encoder_pkg::*;

  logic                             start;
  logic [WORD_WIDTH-1:0]            value_in;
  logic                             busy;
  logic                             done;
  logic                             valid;
  logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand_out;
  logic                             inverted;

  modport master (
    output start, value_in,
    input  busy, done, valid, shift_operand_out, inverted
  );

  modport slave (
    input  start, value_in,
    output busy, done, valid, shift_operand_out, inverted
  );

endinterface

// File: rtl/imm_rotate_encoder_rol_even.sv
// Purpose: combinational 32-bit rotate-left by an even amount 2*rot.
// Latency: zero cycles. Backpressure: none, pure function of its inputs.
module imm_rotate_encoder_rol_even
  import imm_rotate_encoder_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] value,
  input  logic [ROT_WIDTH-1:0]  rot,
  output logic [WORD_WIDTH-1:0] result
);

  logic [ROT_WIDTH:0] amt;

  assign amt = {rot, 1'b0};

  // A zero amount shifts the right half out by a full word, which yields zero.
  assign result = (value << amt) | (value >> (6'(WORD_WIDTH) - {1'b0, amt}));

endmodule

// File: rtl/imm_rotate_encoder.sv
// Purpose: find the smallest rot with value == ror(imm8, 2*rot); IMM_ENC_INVERT_EN adds an MVN (~value) pass.
// Latency: done in cycle rot+2 after start; miss 17 cycles (33 with IMM_ENC_INVERT_EN).
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
module imm_rotate_encoder
  import imm_rotate_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  imm_rotate_encoder_if.slave bus
);

  enc_state_e            state_q, state_d;
  logic [ROT_WIDTH-1:0]  rot_q, rot_d;
  logic [WORD_WIDTH-1:0] value_q, value_d;
  logic [WORD_WIDTH-1:0] search_word;
  logic [WORD_WIDTH-1:0] cand;
  shifter_operand_t      operand_q, operand_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  hit;
  logic                  last_rot;
`ifdef IMM_ENC_INVERT_EN
  logic                  inv_q, inv_d;
`endif

`ifdef IMM_ENC_INVERT_EN
  assign search_word = (state_q == INV_SEARCH) ? ~value_q : value_q;
`else
  assign search_word = value_q;
`endif

  imm_rotate_encoder_rol_even u_rol_even (
    .value  (search_word),
    .rot    (rot_q),
    .result (cand)
  );

  // Rotating left by 2*rot undoes ror(imm8, 2*rot); a hit leaves only the low byte set.
  assign hit      = (cand[WORD_WIDTH-1:IMM_WIDTH] == '0);
  assign last_rot = (rot_q == ROT_WIDTH'(ROT_STEPS - 1));

  always_comb begin
    state_d   = state_q;
    rot_d     = rot_q;
    value_d   = value_q;
    operand_d = operand_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
`ifdef IMM_ENC_INVERT_EN
    inv_d     = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SEARCH;
          rot_d     = '0;
          value_d   = bus.value_in;
          operand_d = '0;
          valid_d   = 1'b0;
`ifdef IMM_ENC_INVERT_EN
          inv_d     = 1'b0;
`endif
        end
      end
      SEARCH: begin
        if (hit) begin
          state_d   = PUBLISH;
          done_d    = 1'b1;
          valid_d   = 1'b1;
          operand_d = '{rot: rot_q, imm8: cand[IMM_WIDTH-1:0]};
        end else if (last_rot) begin
`ifdef IMM_ENC_INVERT_EN
          state_d = INV_SEARCH;
          rot_d   = '0;
`else
          state_d = PUBLISH;
          done_d  = 1'b1;
`endif
        end else begin
          rot_d = rot_q + ROT_WIDTH'(1);
        end
      end
`ifdef IMM_ENC_INVERT_EN
      INV_SEARCH: begin
        if (hit) begin
          state_d   = PUBLISH;
          done_d    = 1'b1;
          valid_d   = 1'b1;
          inv_d     = 1'b1;
          operand_d = '{rot: rot_q, imm8: cand[IMM_WIDTH-1:0]};
        end else if (last_rot) begin
          state_d = PUBLISH;
          done_d  = 1'b1;
        end else begin
          rot_d = rot_q + ROT_WIDTH'(1);
        end
      end
`endif
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rot_q     <= '0;
      value_q   <= '0;
      operand_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rot_q     <= rot_d;
      value_q   <= value_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
`ifdef IMM_ENC_INVERT_EN
      inv_q     <= inv_d;
`endif
    end
  end

  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = done_q;
  assign bus.valid             = valid_q;
  assign bus.shift_operand_out = operand_q;
`ifdef IMM_ENC_INVERT_EN
  assign bus.inverted          = inv_q;
`else
  assign bus.inverted          = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Bench for imm_rotate_encoder: directed vector table, handshake/reset sequences, random values vs a brute-force model.
module tb_imm_rotate_encoder;
  import imm_rotate_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_rotate_encoder_if bus();

  imm_rotate_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef IMM_ENC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] value;
    logic        exp_valid;
    logic [11:0] exp_op;
    logic        exp_inv;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] shift_by(input shift_code_t code, input logic [31:0] x, input int amt);
    case (code)
      SHIFT_LSL: return x << amt;
      SHIFT_LSR: return x >> amt;
      SHIFT_ASR: return $unsigned($signed(x) >>> amt);
      default:   return ror32(x, amt);
    endcase
  endfunction

  // Operand-2 immediate decode: ror(zero-extended imm8, 2*rot).
  function automatic logic [31:0] decode_op2(input logic [11:0] op);
    return shift_by(SHIFT_ROR, {24'h0, op[7:0]}, 2 * int'(op[11:8]));
  endfunction

  // Exhaustive search over all (rot, imm8) pairs, smallest rot first.
  task automatic model(input logic [31:0] v, output logic ok, output logic [11:0] op,
                       output logic inv, output int lat);
    logic [31:0] tgt;
    ok = 1'b0; op = '0; inv = 1'b0; lat = 17;
    for (int pass = 0; pass < (INV_EN ? 2 : 1); pass++) begin
      tgt = (pass == 0) ? v : ~v;
      for (int r = 0; r < 16 && !ok; r++)
        for (int i = 0; i < 256 && !ok; i++)
          if (ror32(i, 2 * r) == tgt) begin
            ok  = 1'b1;
            op  = 12'((r << 8) | i);
            inv = (pass == 1);
            lat = 16 * pass + r + 2;
          end
      if (!ok && pass == 1) lat = 33;
    end
  endtask

  // Assumes the current time is the negedge of cycle 1 of a search; returns at the done negedge.
  task automatic wait_done(input int poke, input logic [31:0] poke_val, output int lat);
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      bus.start = (c == poke);
      if (c == poke) bus.value_in = poke_val;
      if (bus.done) lat = c;
    end
    bus.start = 1'b0;
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [31:0] v, input int poke, input logic [31:0] poke_val, output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.value_in = v;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.value_in = $urandom;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("valid_cleared_on_start", 32'(bus.valid), 32'd0);
    wait_done(poke, poke_val, lat);
  endtask

  initial begin
    logic [31:0] v, tgt;
    logic        m_ok, m_inv;
    logic [11:0] m_op;
    int          lat, kind, r, imm;

    tbl[0] = '{32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 2};
    tbl[1] = '{32'h0000_0000, 1'b1, 12'h000, 1'b0, 2};
    tbl[2] = '{32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 6};
    tbl[3] = '{32'h0000_03FC, 1'b1, 12'hFFF, 1'b0, 17};
    tbl[4] = '{32'h8000_0001, 1'b1, 12'h106, 1'b0, 3};
    tbl[5] = '{32'hF000_000F, 1'b1, 12'h2FF, 1'b0, 4};
    tbl[6] = '{32'h0000_0101, 1'b0, 12'h000, 1'b0, INV_EN ? 33 : 17};
    tbl[7] = '{32'hFFFF_FF00, INV_EN, INV_EN ? 12'h0FF : 12'h000, INV_EN, INV_EN ? 18 : 17};

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.value_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_op", 32'(bus.shift_operand_out), 32'd0);
    chk("rst_inv", 32'(bus.inverted), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    foreach (tbl[i]) begin
      run(tbl[i].value, 0, 32'd0, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_op", i), 32'(bus.shift_operand_out), 32'(tbl[i].exp_op));
      chk($sformatf("tbl%0d_inv", i), 32'(bus.inverted), 32'(tbl[i].exp_inv));
      if (tbl[i].exp_valid) begin
        tgt = tbl[i].exp_inv ? ~tbl[i].value : tbl[i].value;
        chk($sformatf("tbl%0d_roundtrip", i), decode_op2(bus.shift_operand_out), tgt);
      end
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), 32'(bus.done), 32'd0);
      chk($sformatf("tbl%0d_idle", i), 32'(bus.busy), 32'd0);
      chk($sformatf("tbl%0d_op_held", i), 32'(bus.shift_operand_out), 32'(tbl[i].exp_op));
    end

    // start plus a new value in cycle 3 of a busy search must not restart it
    run(32'hFF00_0000, 3, 32'h0000_00FF, lat);
    chk("poke_lat", 32'(lat), 32'd6);
    chk("poke_op", 32'(bus.shift_operand_out), 32'h4FF);

    // start raised in the done cycle is ignored, then accepted on the first IDLE cycle
    run(32'h0000_00FF, 0, 32'd0, lat);
    chk("pre_done_lat", 32'(lat), 32'd2);
    bus.start    = 1'b1;
    bus.value_in = 32'hFF00_0000;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
    chk("valid_held_idle", 32'(bus.valid), 32'd1);
    @(negedge clk);
    chk("start_next_accepted", 32'(bus.busy), 32'd1);
    wait_done(0, 32'd0, lat);
    chk("post_done_lat", 32'(lat), 32'd6);
    chk("post_done_op", 32'(bus.shift_operand_out), 32'h4FF);

    // reset during the rot=5 candidate aborts with no done pulse
    @(negedge clk);
    bus.start    = 1'b1;
    bus.value_in = 32'h0000_0101;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    chk("abort_op", 32'(bus.shift_operand_out), 32'd0);
    chk("abort_inv", 32'(bus.inverted), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_idle", 32'(bus.busy), 32'd0);
      chk("abort_idle_done", 32'(bus.done), 32'd0);
    end

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 15);
      imm  = $urandom_range(0, 255);
      case (kind)
        0:       v = $urandom;
        1:       v = ror32(imm, 2 * r);
        2:       v = ~ror32(imm, 2 * r);
        default: v = imm << $urandom_range(0, 24);
      endcase
      model(v, m_ok, m_op, m_inv, lat);
      tgt = m_inv ? ~v : v;
      run(v, 0, 32'd0, r);
      chk($sformatf("rnd%0d_lat(%08h)", n, v), 32'(r), 32'(lat));
      chk($sformatf("rnd%0d_valid(%08h)", n, v), 32'(bus.valid), 32'(m_ok));
      chk($sformatf("rnd%0d_op(%08h)", n, v), 32'(bus.shift_operand_out), 32'(m_op));
      chk($sformatf("rnd%0d_inv(%08h)", n, v), 32'(bus.inverted), 32'(m_inv));
      if (m_ok)
        chk($sformatf("rnd%0d_roundtrip(%08h)", n, v), decode_op2(bus.shift_operand_out), tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
